// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - shared format codes, opcodes and buffer states for the immediate generator
//
// Purpose: single source for the format-code and opcode constants used by
// imm_decode and imm_gen_stage, plus the output-buffer state encoding.
// Ports: none (package).

package imm_pkg;

    // Format codes reported on out_fmt
    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    // Major opcodes, instr[6:0]
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;

    // Output buffer occupancy
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } buf_state_e;

endpackage

// File: rtl/imm_decode.sv
// rtl/imm_decode.sv - combinational instruction format decode and immediate extraction
//
// Purpose: classify a raw instruction word by opcode and produce its
// sign-extended immediate (or zero-extended shift amount for OP-IMM shifts).
// Ports:
//   instr [31:0]     - raw instruction word
//   fmt   [2:0]      - format code (FMT_* from imm_pkg)
//   imm   [XLEN-1:0] - extended immediate, zero for R and ILL

module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [2:0]      fmt,
    output logic [XLEN-1:0] imm
);

    logic [6:0] opc;
    logic [2:0] funct3;

    assign opc    = instr[6:0];
    assign funct3 = instr[14:12];

    always_comb begin
        fmt = FMT_ILL;
        case (opc)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: fmt = FMT_I;
            OPC_STORE:                                  fmt = FMT_S;
            OPC_BRANCH:                                 fmt = FMT_B;
            OPC_LUI, OPC_AUIPC:                         fmt = FMT_U;
            OPC_JAL:                                    fmt = FMT_J;
            OPC_OP:                                     fmt = FMT_R;
            // Word-sized ops only exist on RV64
            OPC_OP_IMM_32: fmt = (XLEN == 64) ? FMT_I : FMT_ILL;
            OPC_OP_32:     fmt = (XLEN == 64) ? FMT_R : FMT_ILL;
            default:       fmt = FMT_ILL;
        endcase
    end

    // The size casts of signed expressions perform the sign extension to XLEN.
    always_comb begin
        imm = '0;
        case (fmt)
            FMT_I: imm = XLEN'($signed(instr[31:20]));
            FMT_S: imm = XLEN'($signed({instr[31:25], instr[11:7]}));
            FMT_B: imm = XLEN'($signed({instr[31], instr[7], instr[30:25],
                                        instr[11:8], 1'b0}));
            FMT_U: imm = XLEN'($signed({instr[31:12], 12'b0}));
            FMT_J: imm = XLEN'($signed({instr[31], instr[19:12], instr[20],
                                        instr[30:21], 1'b0}));
            default: imm = '0;
        endcase
        // slli/srli/srai carry a shift amount, not a signed immediate
        if (opc == OPC_OP_IMM && (funct3 == 3'b001 || funct3 == 3'b101)) begin
            if (XLEN == 64) begin
                imm = XLEN'(instr[25:20]);
            end else begin
                imm = XLEN'(instr[24:20]);
            end
        end
    end

endmodule

// File: rtl/imm_gen_stage.sv
// rtl/imm_gen_stage.sv - pipelined immediate generator with skid-buffered output and illegal counter
//
// Purpose: accept instructions over a valid/ready handshake, decode them via
// imm_decode, and present results through an output register backed by one
// skid register so in_ready can be registered. Counts accepted ILL opcodes.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   in_valid/in_ready - input handshake; in_instr is the instruction word
//   out_valid/out_ready - output handshake; out_imm/out_fmt are the result
//   cnt_clr           - synchronous clear of illegal_cnt (wins over increment)
//   illegal_cnt       - saturating count of accepted illegal instructions

module imm_gen_stage
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] illegal_cnt
);

    buf_state_e        state_q, state_d;
    logic              in_ready_q;
    logic [XLEN-1:0]   out_imm_q, out_imm_d;
    logic [2:0]        out_fmt_q, out_fmt_d;
    logic [XLEN-1:0]   skid_imm_q, skid_imm_d;
    logic [2:0]        skid_fmt_q, skid_fmt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [XLEN-1:0]   dec_imm;
    logic [2:0]        dec_fmt;
    logic              accept;
    logic              xfer;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr (in_instr),
        .fmt   (dec_fmt),
        .imm   (dec_imm)
    );

    assign accept = in_valid && in_ready_q;
    assign xfer   = (state_q != ST_EMPTY) && out_ready;

    always_comb begin
        state_d    = state_q;
        out_imm_d  = out_imm_q;
        out_fmt_d  = out_fmt_q;
        skid_imm_d = skid_imm_q;
        skid_fmt_d = skid_fmt_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d   = ST_ONE;
                    out_imm_d = dec_imm;
                    out_fmt_d = dec_fmt;
                end
            end
            ST_ONE: begin
                if (accept && xfer) begin
                    out_imm_d = dec_imm;
                    out_fmt_d = dec_fmt;
                end else if (accept) begin
                    // Consumer stalled: park the new entry behind the output
                    state_d    = ST_TWO;
                    skid_imm_d = dec_imm;
                    skid_fmt_d = dec_fmt;
                end else if (xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // in_ready is low here, so only a drain can happen
                if (xfer) begin
                    state_d   = ST_ONE;
                    out_imm_d = skid_imm_q;
                    out_fmt_d = skid_fmt_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (accept && dec_fmt == FMT_ILL && cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
            out_imm_q  <= '0;
            out_fmt_q  <= '0;
            skid_imm_q <= '0;
            skid_fmt_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            // Registered from next state so out_ready never reaches in_ready combinationally
            in_ready_q <= (state_d != ST_TWO);
            out_imm_q  <= out_imm_d;
            out_fmt_q  <= out_fmt_d;
            skid_imm_q <= skid_imm_d;
            skid_fmt_q <= skid_fmt_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = (state_q != ST_EMPTY);
    assign out_imm     = out_imm_q;
    assign out_fmt     = out_fmt_q;
    assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// tb/tb_imm_gen_stage.sv - scoreboard bench for imm_gen_stage at XLEN=32 and XLEN=64

module tb_imm_gen_stage;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        v32, rdy32, ov32, ordy32, clr32;
    logic [31:0] ins32, imm32;
    logic [2:0]  fmt32;
    logic [1:0]  cnt32;

    logic        v64, rdy64, ov64, ordy64, clr64;
    logic [31:0] ins64;
    logic [63:0] imm64;
    logic [2:0]  fmt64;
    logic [15:0] cnt64;

    imm_gen_stage #(.XLEN(32), .CNT_W(2)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(rdy32), .in_instr(ins32),
        .out_valid(ov32), .out_ready(ordy32), .out_imm(imm32), .out_fmt(fmt32),
        .cnt_clr(clr32), .illegal_cnt(cnt32)
    );

    imm_gen_stage #(.XLEN(64), .CNT_W(16)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(v64), .in_ready(rdy64), .in_instr(ins64),
        .out_valid(ov64), .out_ready(ordy64), .out_imm(imm64), .out_fmt(fmt64),
        .cnt_clr(clr64), .illegal_cnt(cnt64)
    );

    typedef struct packed {
        logic [63:0] imm;
        logic [2:0]  fmt;
    } exp_t;

    typedef struct {
        bit          is64;
        logic [31:0] ins;
        logic [63:0] imm;
        logic [2:0]  fmt;
    } vec_t;

    exp_t q32[$];
    exp_t q64[$];
    exp_t nxt32, nxt64;
    vec_t vt[$];

    int n_cmp = 0;
    int n_bad = 0;
    int out32_cnt = 0;
    bit last_acc32, last_acc64;
    bit rnd_rdy = 0;
    bit hold32 = 0, hold64 = 0;
    logic [63:0] held_imm32, held_imm64;
    logic [2:0]  held_fmt32, held_fmt64;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One cycle: sample both DUTs (outputs are registered, inputs already set),
    // update scoreboards, then advance to 1ns after the next rising edge.
    task automatic tick();
        exp_t e;
        if (rnd_rdy) begin
            ordy32 = 1'($urandom_range(0, 1));
            ordy64 = 1'($urandom_range(0, 1));
        end
        if (hold32 && ov32) begin
            chk("dut32 stall hold imm", {32'd0, imm32}, held_imm32);
            chk("dut32 stall hold fmt", 64'(fmt32), 64'(held_fmt32));
        end
        if (hold64 && ov64) begin
            chk("dut64 stall hold imm", imm64, held_imm64);
            chk("dut64 stall hold fmt", 64'(fmt64), 64'(held_fmt64));
        end
        hold32 = ov32 && !ordy32;
        held_imm32 = {32'd0, imm32};
        held_fmt32 = fmt32;
        hold64 = ov64 && !ordy64;
        held_imm64 = imm64;
        held_fmt64 = fmt64;

        last_acc32 = v32 && rdy32;
        last_acc64 = v64 && rdy64;
        if (ov32 && ordy32) begin
            out32_cnt++;
            if (q32.size() == 0) begin
                chk("dut32 spurious out_valid", 64'(ov32), 64'd0);
            end else begin
                e = q32.pop_front();
                chk("dut32 out_imm", {32'd0, imm32}, e.imm);
                chk("dut32 out_fmt", 64'(fmt32), 64'(e.fmt));
            end
        end
        if (ov64 && ordy64) begin
            if (q64.size() == 0) begin
                chk("dut64 spurious out_valid", 64'(ov64), 64'd0);
            end else begin
                e = q64.pop_front();
                chk("dut64 out_imm", imm64, e.imm);
                chk("dut64 out_fmt", 64'(fmt64), 64'(e.fmt));
            end
        end
        if (last_acc32) q32.push_back(nxt32);
        if (last_acc64) q64.push_back(nxt64);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit is64, input logic [31:0] ins,
                        input logic [63:0] eimm, input logic [2:0] efmt);
        bit got;
        got = 0;
        if (is64) begin
            v64 = 1'b1;
            ins64 = ins;
            nxt64 = '{imm: eimm, fmt: efmt};
        end else begin
            v32 = 1'b1;
            ins32 = ins;
            nxt32 = '{imm: eimm, fmt: efmt};
        end
        for (int k = 0; k < 40 && !got; k++) begin
            tick();
            got = is64 ? last_acc64 : last_acc32;
        end
        v32 = 1'b0;
        v64 = 1'b0;
        if (!got) chk("accept timeout", 64'(got), 64'd1);
    endtask

    task automatic drain();
        rnd_rdy = 0;
        ordy32 = 1'b1;
        ordy64 = 1'b1;
        for (int k = 0; k < 40 && (q32.size() != 0 || q64.size() != 0); k++) tick();
        chk("drain dut32 queue empty", 64'(q32.size()), 64'd0);
        chk("drain dut64 queue empty", 64'(q64.size()), 64'd0);
        chk("drain dut32 out_valid idle", 64'(ov32), 64'd0);
        chk("drain dut64 out_valid idle", 64'(ov64), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int idx;
        int base_out;

        vt.push_back('{0, 32'hFFF00093, 64'hFFFFFFFF, 3'd1});
        vt.push_back('{0, 32'h00112623, 64'h0000000C, 3'd2});
        vt.push_back('{0, 32'hFE000EE3, 64'hFFFFFFFC, 3'd3});
        vt.push_back('{0, 32'h123452B7, 64'h12345000, 3'd4});
        vt.push_back('{0, 32'h4030D093, 64'h00000003, 3'd1});
        vt.push_back('{0, 32'hFF9FF0EF, 64'hFFFFFFF8, 3'd5});
        vt.push_back('{0, 32'h00B50533, 64'h00000000, 3'd0});
        vt.push_back('{0, 32'h00412083, 64'h00000004, 3'd1});
        vt.push_back('{0, 32'h01F09093, 64'h0000001F, 3'd1});
        vt.push_back('{0, 32'h0010009B, 64'h00000000, 3'd7});
        vt.push_back('{1, 32'h0010009B, 64'h0000000000000001, 3'd1});
        vt.push_back('{1, 32'h03F0D093, 64'h000000000000003F, 3'd1});
        vt.push_back('{1, 32'h43F0D093, 64'h000000000000003F, 3'd1});
        vt.push_back('{1, 32'h800002B7, 64'hFFFFFFFF80000000, 3'd4});
        vt.push_back('{1, 32'h00B5053B, 64'h0000000000000000, 3'd0});
        vt.push_back('{1, 32'hFE000EE3, 64'hFFFFFFFFFFFFFFFC, 3'd3});
        vt.push_back('{1, 32'h0000007F, 64'h0000000000000000, 3'd7});

        v32 = 0; ins32 = '0; ordy32 = 1; clr32 = 0;
        v64 = 0; ins64 = '0; ordy64 = 1; clr64 = 0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", 64'(ov32), 64'd0);
        chk("reset in_ready", 64'(rdy32), 64'd1);
        chk("reset out_imm", {32'd0, imm32}, 64'd0);
        chk("reset out_fmt", 64'(fmt32), 64'd0);
        chk("reset illegal_cnt", 64'(cnt32), 64'd0);
        chk("reset dut64 out_valid", 64'(ov64), 64'd0);
        chk("reset dut64 illegal_cnt", 64'(cnt64), 64'd0);
        rst_n = 1'b1;

        // First accept on the first edge after release; result one cycle later
        v32 = 1'b1;
        ins32 = 32'hFFF00093;
        nxt32 = '{imm: 64'hFFFFFFFF, fmt: 3'd1};
        tick();
        v32 = 1'b0;
        chk("first accept after reset", 64'(last_acc32), 64'd1);
        chk("latency out_valid", 64'(ov32), 64'd1);
        tick();
        chk("single result retires", 64'(ov32), 64'd0);

        // Full-rate stream with out_ready=1, then with random out_ready
        foreach (vt[i]) if (!vt[i].is64) send(0, vt[i].ins, vt[i].imm, vt[i].fmt);
        drain();
        rnd_rdy = 1;
        foreach (vt[i]) if (!vt[i].is64) send(0, vt[i].ins, vt[i].imm, vt[i].fmt);
        drain();

        // Backpressure: 4 stalled cycles with in_valid held high
        base_out = out32_cnt;
        idx = 0;
        ordy32 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            v32 = 1'b1;
            ins32 = vt[idx].ins;
            nxt32 = '{imm: vt[idx].imm, fmt: vt[idx].fmt};
            tick();
            if (last_acc32) idx++;
        end
        chk("bp accepts while stalled", 64'(idx), 64'd2);
        chk("bp in_ready low when full", 64'(rdy32), 64'd0);
        chk("bp out_valid while stalled", 64'(ov32), 64'd1);
        ordy32 = 1'b1;
        for (int c = 0; c < 20 && idx < 5; c++) begin
            v32 = 1'b1;
            ins32 = vt[idx].ins;
            nxt32 = '{imm: vt[idx].imm, fmt: vt[idx].fmt};
            tick();
            if (last_acc32) idx++;
        end
        v32 = 1'b0;
        chk("bp all accepted", 64'(idx), 64'd5);
        drain();
        chk("bp result count", 64'(out32_cnt - base_out), 64'd5);

        // Saturating illegal counter (CNT_W=2)
        clr32 = 1'b1;
        tick();
        clr32 = 1'b0;
        chk("cnt_clr idle", 64'(cnt32), 64'd0);
        for (int n = 1; n <= 5; n++) begin
            send(0, 32'h0000007F, 64'd0, 3'd7);
            chk("illegal_cnt step", 64'(cnt32), (n < 3) ? 64'(n) : 64'd3);
        end
        clr32 = 1'b1;
        send(0, 32'h0000007F, 64'd0, 3'd7);
        clr32 = 1'b0;
        chk("cnt_clr beats increment", 64'(cnt32), 64'd0);
        drain();

        // Asynchronous reset while holding two entries
        ordy32 = 1'b0;
        send(0, vt[1].ins, vt[1].imm, vt[1].fmt);
        send(0, vt[2].ins, vt[2].imm, vt[2].fmt);
        chk("two entries in_ready low", 64'(rdy32), 64'd0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async reset out_valid", 64'(ov32), 64'd0);
        chk("async reset in_ready", 64'(rdy32), 64'd1);
        q32.delete();
        q64.delete();
        hold32 = 0;
        hold64 = 0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        ordy32 = 1'b1;
        repeat (4) tick();
        chk("no stale output after reset", 64'(ov32), 64'd0);
        chk("counter after reset", 64'(cnt32), 64'd0);

        // XLEN=64 instance, ready then random ready
        foreach (vt[i]) if (vt[i].is64) send(1, vt[i].ins, vt[i].imm, vt[i].fmt);
        drain();
        rnd_rdy = 1;
        foreach (vt[i]) if (vt[i].is64) send(1, vt[i].ins, vt[i].imm, vt[i].fmt);
        drain();
        chk("dut64 illegal_cnt", 64'(cnt64), 64'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
